mem_arbiter: RTL
================

# mem_arbiter

- Round-robin request arbiter that sits directly upstream of the dual-port data DRAM. It lets up to NUM_CORES cores share the DRAM.
- Each cycle it issues one of the following:
  - one write on DRAM port 1, or
  - up to two reads, one on each DRAM port.
- Read responses come back to the requesting core with a fixed one-cycle latency.
- The DRAM port 2 write path is never used.

## Interface

Parameters:
- NUM_CORES, 4: number of requestors; allowed range 2–8.
- ADDR_LIMIT, 1024: highest valid word address, inclusive.

Ports:
- clk  in  1: system clock; all state changes on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  NUM_CORES: per-core request valid.
- req_we  in  NUM_CORES: per-core write (1) or read (0).
- req_addr  in  16*NUM_CORES: per-core word address; core i uses bits [16i+15:16i].
- req_wdata  in  16*NUM_CORES: per-core write data, same packing as req_addr.
- req_ready  out  NUM_CORES: per-core accept; a request is consumed when valid and ready are both high at a rising edge.
- resp_valid  out  NUM_CORES: per-core read data valid, one-cycle pulse.
- resp_rdata  out  16*NUM_CORES: per-core read data; only meaningful while resp_valid is high.
- resp_err  out  NUM_CORES: out-of-range flag; only present when MEM_ARB_BOUNDS_CHECK_EN is defined.
- mem_we_1  out  1: DRAM port 1 write enable.
- mem_addr_1  out  16: DRAM port 1 address.
- mem_wdata_1  out  16: DRAM port 1 write data.
- mem_rdata_1  in  16: DRAM port 1 registered read data.
- mem_we_2  out  1: DRAM port 2 write enable; constant 0.
- mem_addr_2  out  16: DRAM port 2 address.
- mem_wdata_2  out  16: DRAM port 2 write data; constant 0.
- mem_rdata_2  in  16: DRAM port 2 registered read data.

## Operation

- State:
  - rr_ptr, a log2(NUM_CORES)-bit round-robin pointer.
  - Two response tag registers, tag1 and tag2. Each holds a valid bit and a core index.
- Winner selection (combinational): scan cores in the order rr_ptr, rr_ptr+1, … modulo NUM_CORES. The first core with req_valid high is the primary winner.
- Primary is a write:
  - Drive mem_we_1=1, mem_addr_1 and mem_wdata_1 from that core.
  - Only that core gets req_ready.
  - No read is issued this cycle.
- Primary is a read:
  - Drive it on port 1 with mem_we_1=0.
  - Continue the scan after the primary and take the first further core with req_valid=1 and req_we=0 as the secondary. Drive its address on port 2.
  - Both cores get req_ready.
  - Writes met during this continued scan stay pending; they are not served this cycle.
- With no winner:
  - mem_we_1=0 and mem_addr_1=mem_addr_2=0.
  - All req_ready are low.
- req_ready depends combinationally on req_valid. A core must hold its request stable until it sees ready.
- rr_ptr update on each edge with at least one grant: rr_ptr becomes (last granted core in scan order)+1 modulo NUM_CORES. With no grant, rr_ptr holds.
- Read tracking: a granted read on port p loads tagp with {1, core index}. Otherwise tagp.valid is cleared.
- Responses:
  - resp_valid[i] = (tag1.valid and tag1.idx==i) or (tag2.valid and tag2.idx==i).
  - resp_rdata for core i is mem_rdata_1 if tag1 matches i, else mem_rdata_2.
  - A core never holds both tags in the same cycle, because a core is granted at most once per cycle.
- Responses are never back-pressured. A core may issue back-to-back reads.

## Timing

- Request accepted at edge T; DRAM read performed at edge T; resp_valid is high for exactly the cycle after edge T.
- Write accepted at edge T; the DRAM array is updated at edge T; there is no response.
- Throughput:
  - 1 write per cycle, or
  - 2 reads per cycle.
- A write followed by a read of the same address in the next cycle returns the new data.
- Reset values:
  - rr_ptr=0; tag1.valid=tag2.valid=0.
  - resp_valid=0, resp_err=0, req_ready=0.
  - mem_we_1=mem_we_2=0; mem_addr_1=mem_addr_2=0.
- Reset asserted between grant and response: the response is dropped and resp_valid stays 0.
- Single requester: it is granted every cycle regardless of rr_ptr.
- rr_ptr wraps from NUM_CORES-1 to 0.

## Configuration

- MEM_ARB_BOUNDS_CHECK_EN defined:
  - A request with addr > ADDR_LIMIT is still granted and still advances rr_ptr, but it is not driven to the DRAM. mem_we stays 0 and the port address is 0.
  - For an out-of-range read, the next cycle returns resp_valid=1, resp_err=1 and resp_rdata=16'hDEAD.
  - For an out-of-range write, the write is silently dropped.
  - The tag registers carry an err bit.
- MEM_ARB_BOUNDS_CHECK_EN undefined:
  - resp_err is absent.
  - Addresses pass through unchecked.

## Test plan

- Reset release, no requests → all outputs 0; rr_ptr=0; mem_we_1=0 every cycle.
- Core 2 writes 0x1234 to address 10, then reads address 10 in the next cycle → mem_we_1 pulses once; resp_valid[2]=1 one cycle after the read grant, with resp_rdata=0x1234.
- Cores 0–3 all read (addresses 0–3, preloaded 3,3,3,12) held valid → cycle 1 grants cores 0 and 1 (ports 1 and 2), cycle 2 grants cores 2 and 3; each core receives its value exactly one cycle after its grant.
- Core 0 write with rr_ptr=0 while cores 1 and 2 read → cycle 1 performs only the write and rr_ptr=1; cycle 2 grants reads for cores 1 and 2.
- Reset pulsed on the edge after a read grant → no resp_valid; rr_ptr=0 after reset.
- With MEM_ARB_BOUNDS_CHECK_EN: core 1 reads address 2000 → DRAM not accessed; the next cycle gives resp_valid[1]=1, resp_err[1]=1, resp_rdata=0xDEAD.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a dual-port DRAM: one write on port 1 or up to two reads per cycle.
// Optional MEM_ARB_BOUNDS_CHECK_EN adds address range checking with a resp_err flag.
module mem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_LIMIT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    req_valid,
  input  logic [NUM_CORES-1:0]    req_we,
  input  logic [16*NUM_CORES-1:0] req_addr,
  input  logic [16*NUM_CORES-1:0] req_wdata,
  output logic [NUM_CORES-1:0]    req_ready,
  output logic [NUM_CORES-1:0]    resp_valid,
  output logic [16*NUM_CORES-1:0] resp_rdata,
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  output logic [NUM_CORES-1:0]    resp_err,
`endif
  output logic                    mem_we_1,
  output logic [15:0]             mem_addr_1,
  output logic [15:0]             mem_wdata_1,
  input  logic [15:0]             mem_rdata_1,
  output logic                    mem_we_2,
  output logic [15:0]             mem_addr_2,
  output logic [15:0]             mem_wdata_2,
  input  logic [15:0]             mem_rdata_2
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [15:0]          core_addr  [NUM_CORES];
  logic [15:0]          core_wdata [NUM_CORES];
  logic [NUM_CORES-1:0] in_range;
  logic [NUM_CORES-1:0] valid_g;

  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next, last_idx;
  logic             tag1_valid_reg, tag2_valid_reg;
  logic [IDX_W-1:0] tag1_idx_reg, tag2_idx_reg;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
  logic             tag1_err_reg, tag2_err_reg;
`endif

  logic             prim_found, prim_we, sec_found;
  logic [IDX_W-1:0] prim_idx, sec_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign core_addr[gi]  = req_addr[16*gi +: 16];
      assign core_wdata[gi] = req_wdata[16*gi +: 16];
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      assign in_range[gi] = {16'd0, core_addr[gi]} <= 32'(ADDR_LIMIT);
`else
      assign in_range[gi] = 1'b1;
`endif
    end
  endgenerate

  // No grants while reset is asserted, so req_ready and the DRAM controls read as zero.
  assign valid_g = rst_n ? req_valid : '0;

  always_comb begin
    prim_found = 1'b0;
    prim_we    = 1'b0;
    prim_idx   = '0;
    sec_found  = 1'b0;
    sec_idx    = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      int               c;
      logic [IDX_W-1:0] cidx;
      c = int'(rr_ptr_reg) + k;
      if (c >= NUM_CORES) c = c - NUM_CORES;
      cidx = IDX_W'(c);
      if (!prim_found) begin
        if (valid_g[cidx]) begin
          prim_found = 1'b1;
          prim_idx   = cidx;
          prim_we    = req_we[cidx];
        end
      end else if (!prim_we && !sec_found && valid_g[cidx] && !req_we[cidx]) begin
        sec_found = 1'b1;
        sec_idx   = cidx;
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    mem_we_1    = 1'b0;
    mem_addr_1  = '0;
    mem_wdata_1 = '0;
    mem_addr_2  = '0;
    if (prim_found) begin
      req_ready[prim_idx] = 1'b1;
      if (in_range[prim_idx]) begin
        mem_addr_1 = core_addr[prim_idx];
        mem_we_1   = prim_we;
        if (prim_we) mem_wdata_1 = core_wdata[prim_idx];
      end
    end
    if (sec_found) begin
      req_ready[sec_idx] = 1'b1;
      if (in_range[sec_idx]) mem_addr_2 = core_addr[sec_idx];
    end
  end

  assign mem_we_2    = 1'b0;
  assign mem_wdata_2 = '0;

  assign last_idx    = sec_found ? sec_idx : prim_idx;
  assign rr_ptr_next = (int'(last_idx) == NUM_CORES - 1) ? '0 : last_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg     <= '0;
      tag1_valid_reg <= 1'b0;
      tag1_idx_reg   <= '0;
      tag2_valid_reg <= 1'b0;
      tag2_idx_reg   <= '0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      tag1_err_reg   <= 1'b0;
      tag2_err_reg   <= 1'b0;
`endif
    end else begin
      if (prim_found) rr_ptr_reg <= rr_ptr_next;
      tag1_valid_reg <= prim_found && !prim_we;
      tag1_idx_reg   <= prim_idx;
      tag2_valid_reg <= sec_found;
      tag2_idx_reg   <= sec_idx;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      tag1_err_reg   <= !in_range[prim_idx];
      tag2_err_reg   <= !in_range[sec_idx];
`endif
    end
  end

  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_resp
      logic hit1, hit2;
      assign hit1 = tag1_valid_reg && (tag1_idx_reg == IDX_W'(gi));
      assign hit2 = tag2_valid_reg && (tag2_idx_reg == IDX_W'(gi));
      assign resp_valid[gi] = hit1 || hit2;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
      assign resp_err[gi] = (hit1 && tag1_err_reg) || (hit2 && tag2_err_reg);
      assign resp_rdata[16*gi +: 16] = (hit1 ? tag1_err_reg : tag2_err_reg) ? 16'hDEAD
                                     : (hit1 ? mem_rdata_1 : mem_rdata_2);
`else
      assign resp_rdata[16*gi +: 16] = hit1 ? mem_rdata_1 : mem_rdata_2;
`endif
    end
  endgenerate

endmodule
